// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared constants and helpers for the truth-table scanner.
// Holds the FSM state encoding and the table-size helper used to size the
// minterm mask port and the ones counter.
package truth_table_pkg;

  // FSM state encoding (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest and largest supported number of function inputs
  localparam int N_IN_MIN = 32'sd1;
  localparam int N_IN_MAX = 32'sd8;

  // Number of rows in the truth table of an n-input function
  function automatic int tt_size(input int n);
    return 32'sd1 << n;
  endfunction

endpackage

// File: rtl/minterm_counter.sv
// minterm_counter: row index generator for the truth-table scanner.
// Counts 0 .. 2**N_IN-1 and stops at the last row instead of wrapping, so the
// index can never alias back to row 0 inside a scan. 'last' flags the final
// row so the owner can end the scan on the advancing edge.
module minterm_counter
  import truth_table_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [N_IN-1:0] idx,
  output logic            last
);

  logic [N_IN-1:0] count;

  // Row index register: clear has priority, advance stops at the final row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !last) begin
      count <= count + N_IN'(1);
    end else begin
      count <= count;
    end
  end

  // The final row is the all-ones index
  assign last = &count;
  assign idx  = count;

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: streams the rows of an N_IN-input Boolean function.
// The function is given as a minterm mask (bit i = value of minterm i) and is
// latched together with the list-mode flag when a scan starts. Rows leave over
// a valid/ready handshake; in list mode the zero rows are skipped, one cycle
// each, so a scan always spends exactly 2**N_IN cycles in RUN plus stalls.
// Optional feature: define TT_ONES_COUNT_EN to add the ones_count port, a
// saturating count of transferred rows whose value is 1.
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     list_mode,
  input  logic [tt_size(N_IN)-1:0] mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_IN-1:0]          out_index,
  output logic                     out_value,
  output logic                     busy,
  output logic                     done
`ifdef TT_ONES_COUNT_EN
  ,
  output logic [N_IN:0]            ones_count
`endif
);

  localparam int T = tt_size(N_IN);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [T-1:0]    mask_q;
  logic            list_q;
  logic [N_IN-1:0] idx;
  logic            last;
  logic            in_run;
  logic            row_bit;
  logic            row_valid;
  logic            xfer;
  logic            advance;
  logic            clear;

  // Row decode. Everything here depends only on registered state, so the
  // only path from an input to an output is out_ready -> transfer -> state.
  assign in_run    = (state == ST_RUN);
  assign row_bit   = mask_q[idx];
  assign row_valid = in_run && (!list_q || row_bit);
  assign xfer      = row_valid && out_ready;
  // A held row waits for the consumer; a skipped zero row moves on at once
  assign advance   = in_run && (xfer || !row_valid);
  assign clear     = (state == ST_IDLE) && start;

  minterm_counter #(
    .N_IN(N_IN)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .idx    (idx),
    .last   (last)
  );

  // Next-state logic: the advance past the final row ends the scan
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (advance && last) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Function and mode latches: captured only when a scan is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      list_q <= 1'b0;
    end else if (clear) begin
      mask_q <= mask;
      list_q <= list_mode;
    end else begin
      mask_q <= mask_q;
      list_q <= list_q;
    end
  end

  // Outputs are forced to zero outside RUN so no stale row is ever shown
  assign out_valid = row_valid;
  assign out_index = in_run ? idx : '0;
  assign out_value = in_run ? row_bit : 1'b0;
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign done      = (state == ST_DONE);

`ifdef TT_ONES_COUNT_EN
  localparam logic [N_IN:0] ONES_MAX = (N_IN+1)'(T);

  logic [N_IN:0] ones_q;

  // True-minterm counter: cleared per scan, held after DONE, saturates at T
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_q <= '0;
    end else if (clear) begin
      ones_q <= '0;
    end else if (xfer && row_bit && (ones_q != ONES_MAX)) begin
      ones_q <= ones_q + (N_IN+1)'(1);
    end else begin
      ones_q <= ones_q;
    end
  end

  assign ones_count = ones_q;
`endif

endmodule
